decode_regfile_sb: RTL and testbench

DECODE_REGFILE_SB -- requirements
Module: decode_regfile_sb

---
 rtl/decode_regfile_sb_pkg.sv | 24 ++
 rtl/sb_counter.sv | 47 ++++
 rtl/decode_regfile_sb.sv | 103 ++++++++++
 tb/tb_decode_regfile_sb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_regfile_sb_pkg.sv
// Shared sizing constants and helpers for the decode register file
// and its write-pending scoreboard.
package decode_regfile_sb_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 16;
    localparam int PEND_W    = 2;

    localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;

    // Pending count as seen by a reader this cycle: a write-back landing
    // now retires one writer.  Never goes below zero.
    function automatic logic [PEND_W-1:0] eff_pend(
        input logic [PEND_W-1:0] p,
        input logic              wb_hit
    );
        if (wb_hit && (p != '0)) begin
            return p - 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating 0..PEND_MAX in-flight writer counter for one register.
// flag_o pulses when an inc/dec would leave the legal range.
module sb_counter
    import decode_regfile_sb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] count_o,
    output logic              flag_o
);

    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;

    // Next count: inc and dec together cancel; out-of-range holds and flags.
    always_comb begin
        count_d = count_q;
        flag_o  = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == PEND_MAX) begin
                flag_o = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                flag_o = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/decode_regfile_sb.sv
// Decode-stage register file with write-back bypass and a per-register
// write-pending scoreboard that stalls decode on RAW hazards.
module decode_regfile_sb
    import decode_regfile_sb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rd_reg_1,
    input  logic [REG_IDX_W-1:0] rd_reg_2,
    input  logic                 rd_use_1,
    input  logic                 rd_use_2,
    input  logic                 issue_en,
    input  logic                 issue_w_en,
    input  logic [REG_IDX_W-1:0] issue_w_reg,
    input  logic                 wb_w_en,
    input  logic [REG_IDX_W-1:0] wb_w_reg,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [DATA_W-1:0]    data_1,
    output logic [DATA_W-1:0]    data_2,
    output logic                 stall,
    output logic                 err
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [PEND_W-1:0]   pend   [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] flag;
    logic                err_q;
    logic                err_d;
    logic                issue_ok;
    logic                hit_1;
    logic                hit_2;

    assign hit_1 = wb_w_en && (wb_w_reg == rd_reg_1);
    assign hit_2 = wb_w_en && (wb_w_reg == rd_reg_2);

    // Read ports with same-cycle write-back bypass.
    always_comb begin
        data_1 = hit_1 ? wb_data : regs_q[rd_reg_1];
        data_2 = hit_2 ? wb_data : regs_q[rd_reg_2];
    end

    // RAW hazard: a used source still has a writer in flight.
    always_comb begin
        stall = 1'b0;
        if (rd_use_1 && (eff_pend(pend[rd_reg_1], hit_1) != '0)) begin
            stall = 1'b1;
        end
        if (rd_use_2 && (eff_pend(pend[rd_reg_2], hit_2) != '0)) begin
            stall = 1'b1;
        end
    end

    assign issue_ok = issue_en && !stall;

    // One-hot increment/decrement requests per register.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i] = issue_ok && issue_w_en
                  && (issue_w_reg == REG_IDX_W'(i));
            dec[i] = wb_w_en && (wb_w_reg == REG_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
        sb_counter u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (inc[g]),
            .dec_i   (dec[g]),
            .count_o (pend[g]),
            .flag_o  (flag[g])
        );
    end

    assign err_d = err_q | (|flag);

    // Sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    // Register storage; write-back commits even on scoreboard underflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_w_en) begin
            regs_q[wb_w_reg] <= wb_data;
        end
    end

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Scoreboard bench for decode_regfile_sb: directed scenarios plus
// randomized traffic checked against a behavioural model.
module tb_decode_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_reg_1, rd_reg_2;
    logic        rd_use_1, rd_use_2;
    logic        issue_en, issue_w_en;
    logic [2:0]  issue_w_reg;
    logic        wb_w_en;
    logic [2:0]  wb_w_reg;
    logic [15:0] wb_data;
    logic [15:0] data_1, data_2;
    logic        stall, err;

    decode_regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rd_reg_1    (rd_reg_1),
        .rd_reg_2    (rd_reg_2),
        .rd_use_1    (rd_use_1),
        .rd_use_2    (rd_use_2),
        .issue_en    (issue_en),
        .issue_w_en  (issue_w_en),
        .issue_w_reg (issue_w_reg),
        .wb_w_en     (wb_w_en),
        .wb_w_reg    (wb_w_reg),
        .wb_data     (wb_data),
        .data_1      (data_1),
        .data_2      (data_2),
        .stall       (stall),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        st;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    logic [15:0] m_regs [8];
    int          m_pend [8];
    bit          m_err;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs against queued expectations mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("data_1", data_1, e.d1);
            chk("data_2", data_2, e.d2);
            chk("stall", 16'(stall), 16'(e.st));
            chk("err", 16'(err), 16'(e.er));
        end
    end

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic bit m_stall();
        int e1, e2;
        e1 = m_pend[rd_reg_1];
        e2 = m_pend[rd_reg_2];
        if (wb_w_en && wb_w_reg == rd_reg_1) e1 = e1 - 1;
        if (wb_w_en && wb_w_reg == rd_reg_2) e2 = e2 - 1;
        if (e1 < 0) e1 = 0;
        if (e2 < 0) e2 = 0;
        return (rd_use_1 && e1 > 0) || (rd_use_2 && e2 > 0);
    endfunction

    task automatic idle();
        rd_reg_1 = 0; rd_reg_2 = 0; rd_use_1 = 0; rd_use_2 = 0;
        issue_en = 0; issue_w_en = 0; issue_w_reg = 0;
        wb_w_en = 0; wb_w_reg = 0; wb_data = 0;
    endtask

    // One cycle: predict outputs, cross the edge, advance the model.
    task automatic step();
        exp_t e;
        bit   st, acc, same;
        st   = m_stall();
        e.d1 = (wb_w_en && wb_w_reg == rd_reg_1) ? wb_data
                                                 : m_regs[rd_reg_1];
        e.d2 = (wb_w_en && wb_w_reg == rd_reg_2) ? wb_data
                                                 : m_regs[rd_reg_2];
        e.st = st;
        e.er = m_err;
        q.push_back(e);
        @(posedge clk);
        acc  = issue_en && !st && issue_w_en;
        same = acc && wb_w_en && (issue_w_reg == wb_w_reg);
        if (acc && !same) begin
            if (m_pend[issue_w_reg] == 3) m_err = 1'b1;
            else m_pend[issue_w_reg]++;
        end
        if (wb_w_en && !same) begin
            if (m_pend[wb_w_reg] == 0) m_err = 1'b1;
            else m_pend[wb_w_reg]--;
        end
        if (wb_w_en) m_regs[wb_w_reg] = wb_data;
        #1;
    endtask

    // Reset pulse spanning a negedge so the reset-state outputs get checked.
    task automatic pulse_reset();
        exp_t e;
        idle();
        rd_reg_1 = 3;
        rd_use_1 = 1;
        rst = 1'b0;
        m_reset();
        e.d1 = 16'h0; e.d2 = 16'h0; e.st = 1'b0; e.er = 1'b0;
        q.push_back(e);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [2:0] r);
        idle(); issue_en = 1; issue_w_en = 1; issue_w_reg = r; step();
    endtask

    task automatic wb(input logic [2:0] r, input logic [15:0] d);
        idle(); wb_w_en = 1; wb_w_reg = r; wb_data = d; step();
    endtask

    task automatic rd(input logic [2:0] r1, input logic [2:0] r2);
        idle(); rd_reg_1 = r1; rd_reg_2 = r2;
        rd_use_1 = 1; rd_use_2 = 1; step();
    endtask

    initial begin
        idle();
        m_reset();
        rst = 1'b0;
        #12;
        pulse_reset();

        // Reset clears stored data.
        issue(3);
        wb(3, 16'h1234);
        rd(3, 0);
        pulse_reset();
        rd(3, 3);

        // Same-cycle bypass, then committed value.
        issue(5);
        idle(); rd_reg_1 = 5; wb_w_en = 1; wb_w_reg = 5;
        wb_data = 16'hBEEF; step();
        rd(5, 0);

        // RAW stall on R2; ignored issue of R7 while stalled.
        issue(2);
        for (int k = 0; k < 2; k++) begin
            idle(); rd_reg_1 = 2; rd_use_1 = 1;
            issue_en = 1; issue_w_en = 1; issue_w_reg = 7; step();
        end
        idle(); rd_reg_1 = 2; rd_use_1 = 1;
        wb_w_en = 1; wb_w_reg = 2; wb_data = 16'hCAFE; step();
        rd(7, 2);

        // Simultaneous issue and write-back to R4 leaves count at 1.
        issue(4);
        idle(); issue_en = 1; issue_w_en = 1; issue_w_reg = 4;
        wb_w_en = 1; wb_w_reg = 4; wb_data = 16'h4444; step();
        rd(4, 0);
        wb(4, 16'h4445);
        rd(4, 4);

        // Overflow on R6.
        pulse_reset();
        for (int k = 0; k < 4; k++) issue(6);
        rd(6, 0);
        for (int k = 0; k < 3; k++) wb(6, 16'(k));
        rd(6, 6);

        // Underflow on R1 still writes data.
        pulse_reset();
        wb(1, 16'h5555);
        rd(1, 0);

        // Randomized legal-ish traffic.
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            int cand[$];
            idle();
            rd_reg_1 = 3'($urandom_range(0, 7));
            rd_reg_2 = 3'($urandom_range(0, 7));
            rd_use_1 = 1'($urandom_range(0, 1));
            rd_use_2 = 1'($urandom_range(0, 1));
            issue_en = 1'($urandom_range(0, 1));
            issue_w_en = 1'($urandom_range(0, 1));
            issue_w_reg = 3'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++)
                if (m_pend[i] > 0) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb_w_en = 1;
                wb_w_reg = 3'(cand[$urandom_range(0, cand.size() - 1)]);
                wb_data = 16'($urandom);
            end
            step();
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        idle();
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
